// File: rtl/alu_seq_if.sv
// alu_seq operand/result bundle.
// master drives op/a/b with in_valid; slave returns in_ready/result/flags.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with persistent {V,C,N,Z} flag register.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_RLC  = 4'b0110;
    localparam logic [3:0] OP_RRC  = 4'b0111;
    localparam logic [3:0] OP_SETC = 4'b1000;
    localparam logic [3:0] OP_CLRC = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_NEG  = 4'b1011;
    localparam logic [3:0] OP_INC  = 4'b1100;
    localparam logic [3:0] OP_DEC  = 4'b1101;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = '1;

    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic [WIDTH:0]   sum;
    logic             v_n;
    logic             c_n;
    logic             upd_zn;

    logic             mul_start;
    logic             mul_last;
    logic [WIDTH-1:0] mul_res;
    logic [3:0]       mul_flags;

    assign accept = bus.in_valid && bus.in_ready;

    // Single-cycle datapath: new result and flags from operands and held C.
    always_comb begin
        alu_res = result_q;
        v_n     = flags_q[3];
        c_n     = flags_q[2];
        upd_zn  = 1'b1;
        sum     = '0;
        case (bus.op)
            OP_MOV: alu_res = bus.b;
            OP_ADD: begin
                sum     = {1'b0, bus.a} + {1'b0, bus.b};
                alu_res = sum[MSB:0];
                c_n     = sum[WIDTH];
                v_n     = (bus.a[MSB] == bus.b[MSB]) &&
                          (alu_res[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_res = bus.a - bus.b;
                c_n     = bus.a < bus.b;
                v_n     = (bus.a[MSB] != bus.b[MSB]) &&
                          (alu_res[MSB] != bus.a[MSB]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_RLC: begin
                alu_res = {bus.b[MSB-1:0], flags_q[2]};
                c_n     = bus.b[MSB];
            end
            OP_RRC: begin
                alu_res = {flags_q[2], bus.b[MSB:1]};
                c_n     = bus.b[0];
            end
            OP_SETC: begin
                upd_zn = 1'b0;
                c_n    = 1'b1;
            end
            OP_CLRC: begin
                upd_zn = 1'b0;
                c_n    = 1'b0;
            end
            OP_NOT: alu_res = ~bus.b;
            OP_NEG: alu_res = -bus.b;
            OP_INC: begin
                alu_res = bus.b + WIDTH'(1);
                c_n     = bus.b == ALL_ONE;
                v_n     = bus.b == MAX_POS;
            end
            OP_DEC: begin
                alu_res = bus.b - WIDTH'(1);
                c_n     = bus.b == '0;
                v_n     = bus.b == MIN_NEG;
            end
            default: begin
                // Undefined opcodes (and MUL when not built) zero the
                // result but leave every flag alone.
                alu_res = '0;
                upd_zn  = 1'b0;
            end
        endcase
        alu_flags = {v_n, c_n,
                     upd_zn ? alu_res[MSB] : flags_q[1],
                     upd_zn ? (alu_res == '0) : flags_q[0]};
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1110;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_fin;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;

    assign mul_start = accept && (bus.op == OP_MUL);
    assign mul_last  = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
    assign prod_fin  = prod + (mplier[0] ? mcand : '0);
    assign mul_res   = prod_fin[MSB:0];
    assign mul_flags = {prod_fin[2*WIDTH-1:WIDTH] != '0,
                        prod_fin[2*WIDTH-1:WIDTH] != '0,
                        prod_fin[MSB],
                        prod_fin[MSB:0] == '0};

    // Multiplier FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and input-side readiness.
    always_comb begin
        state_n      = state;
        bus.in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (mul_start) state_n = S_MUL;
            end
            S_MUL: begin
                if (mul_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Shift-add iteration: one multiplier bit per cycle, LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (mul_start) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            prod   <= '0;
            mplier <= bus.b;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            prod   <= prod_fin;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end
`else
    assign mul_start    = 1'b0;
    assign mul_last     = 1'b0;
    assign mul_res      = '0;
    assign mul_flags    = '0;
    assign bus.in_ready = 1'b1;
`endif

    // Architectural result/flag register and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (mul_last) begin
                result_q    <= mul_res;
                flags_q     <= mul_flags;
                out_valid_q <= 1'b1;
            end else if (accept && !mul_start) begin
                result_q    <= alu_res;
                flags_q     <= alu_flags;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed plan steps then random ops vs integer model.
// Follows ALU_MUL_EN the same way as the design.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    int m_res;
    bit m_v, m_c, m_n, m_z;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? x - (1 << W) : x;
    endfunction

    function automatic logic [3:0] m_flags();
        return {m_v, m_c, m_n, m_z};
    endfunction

    task automatic model_reset();
        m_res = 0;
        {m_v, m_c, m_n, m_z} = 4'b0000;
    endtask

    task automatic model_step(input int op, input int a, input int b);
        int r;
        int t;
        bit zn;
        r  = m_res;
        zn = 1'b1;
        case (op)
            1: r = b;
            2: begin
                t = a + b;
                r = t & MASK;
                m_c = t > MASK;
                t = sgn(a) + sgn(b);
                m_v = (t > HALF - 1) || (t < -HALF);
            end
            3: begin
                r = (a - b) & MASK;
                m_c = a < b;
                t = sgn(a) - sgn(b);
                m_v = (t > HALF - 1) || (t < -HALF);
            end
            4: r = a & b;
            5: r = a | b;
            6: begin
                r = ((b << 1) | int'(m_c)) & MASK;
                m_c = b >= HALF;
            end
            7: begin
                r = (m_c ? HALF : 0) | (b >> 1);
                m_c = (b & 1) != 0;
            end
            8: begin zn = 1'b0; m_c = 1'b1; end
            9: begin zn = 1'b0; m_c = 1'b0; end
            10: r = MASK - b;
            11: r = (0 - b) & MASK;
            12: begin
                r = (b + 1) & MASK;
                m_c = b == MASK;
                m_v = b == HALF - 1;
            end
            13: begin
                r = (b - 1) & MASK;
                m_c = b == 0;
                m_v = b == HALF;
            end
`ifdef ALU_MUL_EN
            14: begin
                t = a * b;
                r = t & MASK;
                m_c = t > MASK;
                m_v = m_c;
            end
`endif
            default: begin r = 0; zn = 1'b0; end
        endcase
        m_res = r;
        if (zn) begin
            m_z = r == 0;
            m_n = r >= HALF;
        end
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_ov"},  bus.out_valid, 1);
        chk({tag, "_res"}, bus.result, m_res);
        chk({tag, "_flg"}, bus.flags, m_flags());
        chk({tag, "_rdy"}, bus.in_ready, 1);
    endtask

    task automatic issue(input int op, input int a, input int b);
        logic [31:0] o, x, y;
        o = op; x = a; y = b;
        bus.in_valid = 1'b1;
        bus.op = o[3:0];
        bus.a  = x[W-1:0];
        bus.b  = y[W-1:0];
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        model_step(op, a, b);
        check_done("op");
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_ov",  bus.out_valid, 0);
        chk("idle_res", bus.result, m_res);
        chk("idle_flg", bus.flags, m_flags());
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_op(input int a, input int b);
        logic [31:0] x, y;
        x = a; y = b;
        bus.in_valid = 1'b1;
        bus.op = 4'b1110;
        bus.a  = x[W-1:0];
        bus.b  = y[W-1:0];
        @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < W; j++) begin
            chk("mul_busy_rdy", bus.in_ready, 0);
            chk("mul_busy_ov",  bus.out_valid, 0);
            if (j < W - 1) begin
                bus.in_valid = 1'b1;
                bus.op = 4'b0010;
                bus.a  = W'($urandom);
                bus.b  = W'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        model_step(14, a, b);
        check_done("mul");
    endtask
`endif

    initial begin
        int op, a, b;
        bus.in_valid = 1'b0;
        bus.op = 4'b0000;
        bus.a  = '0;
        bus.b  = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_res", bus.result, 0);
        chk("rst_flg", bus.flags, 0);
        chk("rst_rdy", bus.in_ready, 1);
        chk("rst_ov",  bus.out_valid, 0);

        issue(2, 'h7F, 'h01);
        chk("add_res_k", bus.result, 'h80);
        chk("add_flg_k", bus.flags, 4'b1010);
        idle_cycle();

        issue(3, 'h00, 'h01);
        chk("sub_flg_k", bus.flags, 4'b0110);
        issue(4, 'hF0, 'h0F);
        chk("and_flg_k", bus.flags, 4'b0101);

        issue(8, 0, 0);
        chk("setc_res_k", bus.result, 'h00);
        issue(6, 0, 'h80);
        chk("rlc_res_k", bus.result, 'h01);
        chk("rlc_flg_k", bus.flags, 4'b0100);

        issue(12, 0, 'h7F);
        issue(12, 0, 'hFF);
        issue(13, 0, 'h80);
        issue(13, 0, 'h00);
        issue(9, 0, 0);
        issue(7, 0, 'h01);
        issue(0, 'h12, 'h34);
        issue(15, 'h12, 'h34);

`ifdef ALU_MUL_EN
        mul_op('h10, 'h20);
        chk("mul_res_k", bus.result, 'h00);
        chk("mul_flg_k", bus.flags, 4'b1101);
        mul_op('h0F, 'h11);
        chk("mul2_res_k", bus.result, 'hFF);
        idle_cycle();

        bus.in_valid = 1'b1;
        bus.op = 4'b1110;
        bus.a  = 8'h10;
        bus.b  = 8'h20;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_ov",  bus.out_valid, 0);
        chk("abort_flg", bus.flags, 0);
        chk("abort_res", bus.result, 0);
        chk("abort_rdy", bus.in_ready, 1);
        repeat (W) idle_cycle();
`else
        issue(14, 'h10, 'h20);
        chk("nomul_res_k", bus.result, 'h00);
`endif

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, MASK));
            b  = int'($urandom_range(0, MASK));
`ifdef ALU_MUL_EN
            if (op == 14) mul_op(a, b);
            else          issue(op, a, b);
`else
            issue(op, a, b);
`endif
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the combinational 8-bit datapath ALU. Operands and opcode are accepted with a valid/ready handshake. Results and a persistent flag register (Z, N, C, V) are registered, and C feeds the rotate-through-carry ops internally. An optional multi-cycle unsigned shift-add multiplier stalls the input while it is busy. The block sits in the execute stage, between the operand-forwarding muxes and the EX/MEM register.

## Interface
- WIDTH, 8, operand/result width in bits (≥4)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  op/a/b present this cycle
- in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready at an edge
- op  in  4  opcode: 0001 MOV, 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 RLC, 0111 RRC, 1000 SETC, 1001 CLRC, 1010 NOT, 1011 NEG, 1100 INC, 1101 DEC, 1110 MUL
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (the single operand for unary ops)
- out_valid  out  1  one-cycle pulse: result/flags reflect the completed op
- result  out  WIDTH  registered result; holds its value between ops
- flags  out  4  registered {V, C, N, Z}

## Operation
- Reset values: result=0, flags=0, out_valid=0, in_ready=1, FSM=IDLE, multiplier state cleared.
- FSM states:
  - IDLE: in_ready=1. A non-MUL transfer completes at the accepting edge. A MUL transfer goes to MUL.
  - MUL: in_ready=0 and in_valid is ignored. An iteration counter runs WIDTH iterations, then the FSM returns to IDLE.
- Arithmetic (all at WIDTH bits, wrap modulo 2^WIDTH):
  - ADD: C = carry out; V = signed overflow.
  - SUB: a−b; C = borrow (a<b unsigned); V = signed overflow.
  - INC: b+1. C = carry; V = (b = 0111…1).
  - DEC: b−1. C = borrow (b=0); V = (b = 1000…0).
  - NEG: two's complement of b. NOT: ~b.
  - RLC: result={b[WIDTH-2:0], C_reg}, new C=b[WIDTH-1].
  - RRC: result={C_reg, b[WIDTH-1:1]}, new C=b[0].
  - SETC/CLRC: result register unchanged; C set or cleared.
  - MUL: unsigned a×b, result = low WIDTH bits; C = V = (high WIDTH bits ≠ 0).
- Flag update rules:
  - Z and N are computed from the new result for every op except SETC/CLRC. Those two hold Z and N.
  - C is updated by ADD, SUB, INC, DEC, RLC, RRC, SETC, CLRC and MUL. All other ops hold C.
  - V is updated by ADD, SUB, INC, DEC and MUL. All other ops hold V.
- Undefined opcodes (0000, 1111): result=0, flags unchanged, out_valid still pulses.

## Timing
- Non-MUL op accepted at edge k:
  - result, flags and out_valid=1 are visible after edge k, for one cycle.
  - Throughput is one op per cycle.
- Back-to-back ops: an op accepted at edge k+1 sees the C written at edge k. Carry chains (for example SETC then RLC) need no bubble.
- MUL accepted at edge k:
  - in_ready=0 after edge k.
  - Result, flags and out_valid=1 are visible after edge k+WIDTH.
  - in_ready=1 in that same cycle, so a new op may be accepted at edge k+WIDTH+1.
- No output backpressure. out_valid is a pulse and the consumer must capture it.
- rst asserted at any edge, including mid-MUL: all state returns to reset values at that edge. An aborted MUL produces no out_valid and its partial product is discarded.
- in_valid=0: no state change except the MUL iteration; out_valid=0.

## Configuration
- ALU_MUL_EN defined:
  - The MUL state, iteration counter and product registers are compiled in.
  - Opcode 1110 behaves as specified above.
- ALU_MUL_EN undefined:
  - No multiplier logic and no MUL state; in_ready is tied to 1.
  - Opcode 1110 is treated as an undefined opcode: result=0, flags held, single-cycle out_valid.

## Test plan
- Reset: hold rst for 2 cycles, release → result=0, flags=0000, in_ready=1, out_valid=0.
- ADD a=0x7F, b=0x01 → next cycle result=0x80, {V,C,N,Z}=1010, out_valid for exactly one cycle.
- SUB a=0x00, b=0x01 → result=0xFF, C=1, N=1, V=0, Z=0. Then AND a=0xF0, b=0x0F → result=0x00, Z=1, C stays 1.
- Back-to-back SETC then RLC b=0x80 on consecutive cycles → RLC result=0x01, C=1, Z=0, N=0. SETC leaves result, Z and N unchanged.
- MUL a=0x10, b=0x20 (ALU_MUL_EN):
  - in_ready=0 for 8 cycles, and a concurrent in_valid is ignored.
  - out_valid 8 cycles after accept with result=0x00, {V,C,N,Z}=1101.
  - MUL a=0x0F, b=0x11 → result=0xFF, V=C=0.
- Reset mid-MUL: assert rst 3 cycles after MUL accept → no out_valid, flags=0, in_ready=1 the next cycle. Without ALU_MUL_EN, MUL 0x10×0x20 → result=0x00 next cycle, flags unchanged.
